// File: rtl/bcd_para_bin_if.sv
// bcd_para_bin_if: request/result bundle for the sequential BCD-to-binary converter.
// Revision: 1.0
`default_nettype none

interface bcd_para_bin_if;
  logic       start;
  logic [3:0] c;
  logic [3:0] d;
  logic [3:0] u;
  logic [9:0] bin;
  logic       busy;
  logic       done;
  logic       erro;

  modport master (
    output start, c, d, u,
    input  bin, busy, done, erro
  );

  modport slave (
    input  start, c, d, u,
    output bin, busy, done, erro
  );
endinterface

`default_nettype wire

// File: rtl/bcd_para_bin.sv
// bcd_para_bin: three-digit BCD to 10-bit binary, one digit per clock (acc*10 + digit).
// Revision: 1.0
`default_nettype none

module bcd_para_bin (
  input  wire logic     clk,
  input  wire logic     rst,
  bcd_para_bin_if.slave bus
);

  typedef enum logic [0:0] {
    OCIOSO = 1'b0,
    CONV   = 1'b1
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_c, r_d, r_u;
  logic [3:0] w_c_nxt, w_d_nxt, w_u_nxt;
  logic [9:0] r_acc, w_acc_nxt;
  logic [1:0] r_idx, w_idx_nxt;
  logic [9:0] r_bin, w_bin_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_done, w_done_nxt;
  logic       r_erro, w_erro_nxt;

  logic [3:0] w_digit;
  logic [9:0] w_acc_step;
  logic       w_bad;

  assign w_bad = (bus.c > 4'd9) || (bus.d > 4'd9) || (bus.u > 4'd9);

  always_comb begin
    w_digit = r_u;
    case (r_idx)
      2'd0:    w_digit = r_c;
      2'd1:    w_digit = r_d;
      default: w_digit = r_u;
    endcase
  end

  // Result never exceeds 999, so 10-bit arithmetic cannot wrap.
  assign w_acc_step = (r_acc << 3) + (r_acc << 1) + {6'd0, w_digit};

  always_comb begin
    w_state_nxt = r_state;
    w_c_nxt     = r_c;
    w_d_nxt     = r_d;
    w_u_nxt     = r_u;
    w_acc_nxt   = r_acc;
    w_idx_nxt   = r_idx;
    w_bin_nxt   = r_bin;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_erro_nxt  = r_erro;
    case (r_state)
      OCIOSO: begin
        if (bus.start) begin
          if (w_bad) begin
            w_erro_nxt = 1'b1;
            w_done_nxt = 1'b1;
          end else begin
            w_c_nxt     = bus.c;
            w_d_nxt     = bus.d;
            w_u_nxt     = bus.u;
            w_acc_nxt   = 10'd0;
            w_idx_nxt   = 2'd0;
            w_busy_nxt  = 1'b1;
            w_erro_nxt  = 1'b0;
            w_state_nxt = CONV;
          end
        end
      end
      CONV: begin
        w_acc_nxt = w_acc_step;
        w_idx_nxt = r_idx + 2'd1;
        if (r_idx == 2'd2) begin
          w_bin_nxt   = w_acc_step;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_idx_nxt   = 2'd0;
          w_state_nxt = OCIOSO;
        end
      end
      default: w_state_nxt = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= OCIOSO;
      r_c     <= 4'd0;
      r_d     <= 4'd0;
      r_u     <= 4'd0;
      r_acc   <= 10'd0;
      r_idx   <= 2'd0;
      r_bin   <= 10'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_erro  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_c     <= w_c_nxt;
      r_d     <= w_d_nxt;
      r_u     <= w_u_nxt;
      r_acc   <= w_acc_nxt;
      r_idx   <= w_idx_nxt;
      r_bin   <= w_bin_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_erro  <= w_erro_nxt;
    end
  end

  assign bus.bin  = r_bin;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.erro = r_erro;

endmodule

`default_nettype wire

// File: doc/bcd_para_bin.md
# bcd_para_bin

Sequential BCD-to-binary converter for the stopwatch datapath. Accepts three BCD digits (hundreds, tens, units, 000–999) with a start pulse and produces the 10-bit binary value by iterative multiply-by-10-and-add, one digit per clock. It is used where user-entered or displayed BCD values (preset, lap recall) must be fed back into binary counters. Invalid digits (>9) are flagged rather than converted.

## Interface

Parameters:
- none (widths fixed: 3 digits, 10-bit result)

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request conversion; sampled only in state OCIOSO
- c  input  4  hundreds digit (BCD)
- d  input  4  tens digit (BCD)
- u  input  4  units digit (BCD)
- bin  output  10  converted value, registered, held until the next successful conversion
- busy  output  1  high while a conversion is in progress
- done  output  1  one-cycle pulse: result or error available
- erro  output  1  high if the last accepted request had a digit >9; held until next accepted start

## Operation

- Reset (async, rst=1): state=OCIOSO, bin=0, busy=0, done=0, erro=0, internal accumulator=0, digit index=0. Reset mid-conversion aborts it; no done pulse.
- States: OCIOSO, CONV.
- OCIOSO, start=1 at edge N:
  - Any of c,d,u >9: erro<=1, done<=1 at edge N, bin unchanged, stay OCIOSO.
  - Otherwise: latch c,d,u into internal registers, acc<=0, idx<=0, busy<=1, erro<=0, go CONV.
- CONV, one digit per edge, order c, d, u: acc <= acc*10 + digit[idx]; acc*10 computed as (acc<<3)+(acc<<1), all arithmetic 10 bits (max 999, no overflow).
- On the third CONV edge (unit digit): bin<=final value, done<=1, busy<=0, return OCIOSO.
- done is deasserted on every edge where it is not explicitly set (strict one-cycle pulse).
- start while in CONV: ignored; inputs c,d,u may change freely after the start edge (digits were latched).
- start held high continuously: a new request is accepted on the first edge after returning to OCIOSO.

## Timing

- Valid conversion: start sampled at edge N; busy high from edge N to edge N+3; bin and done update at edge N+3; latency 3 clocks.
- Throughput: back-to-back requests accepted at N, N+4, N+8, … (4-cycle cadence).
- Invalid request: done and erro at edge N, latency 0 cycles after sampling edge; busy never asserts; next request may be accepted at N+1.
- done and busy never both high in the same cycle.
- No combinational path from inputs to outputs.

## Test plan

- Reset then c=1,d=2,u=3, start pulse at edge N -> busy=1 for edges N..N+3 interval, at N+3 bin=123, done=1 for exactly one cycle, erro=0.
- Corners: 0,0,0 -> bin=0; 9,9,9 -> bin=999; 0,0,9 -> 9; 9,0,0 -> 900; then full sweep 000–999, each result equals 100c+10d+u after 3 cycles.
- After bin=123, request c=1,d=10(4'hA),u=0 -> done and erro at edge N, bin stays 123, busy stays 0; next valid request 0,4,5 clears erro, bin=45.
- Start 4,5,6; change inputs to 7,8,9 and pulse start during busy -> result 456, second start ignored, no extra done.
- start held high with inputs 2,5,0 -> done pulses every 4 cycles, bin=250 each time.
- Start 8,7,6, assert rst asynchronously between edges N+1 and N+2 -> outputs immediately bin=0, busy=0, done=0, erro=0; no done pulse follows; new request 1,0,1 yields 101.
